// File: rtl/pl_stage_skid.sv
// pl_stage_skid: LANES-wide pipeline stage register with a 2-entry skid buffer.
// The main entry drives out_*; the skid entry absorbs one bundle of
// backpressure so in_ready depends only on registered state.
// Supports per-lane kill of the head entry and a global flush.
module pl_stage_skid #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        kill,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [LANES-1:0]        r_main_v;
  logic [LANES*DATA_W-1:0] r_main_d;
  logic [LANES-1:0]        r_skid_v;
  logic [LANES*DATA_W-1:0] r_skid_d;

  logic                    w_con;
  logic                    w_acc;
  logic                    w_pop;
  logic [LANES-1:0]        w_main_v_kill;

  state_t                  w_state_post;
  logic [LANES-1:0]        w_main_v_post;
  logic [LANES*DATA_W-1:0] w_main_d_post;
  logic [LANES-1:0]        w_skid_v_post;
  logic [LANES*DATA_W-1:0] w_skid_d_post;

  state_t                  w_state_nxt;
  logic [LANES-1:0]        w_main_v_nxt;
  logic [LANES*DATA_W-1:0] w_main_d_nxt;
  logic [LANES-1:0]        w_skid_v_nxt;
  logic [LANES*DATA_W-1:0] w_skid_d_nxt;

  // Handshake terms; in_ready comes from registered state and rst only.
  always_comb begin
    in_ready      = (r_state != ST_TWO) && !rst;
    w_acc         = in_ready && (|in_valid);
    w_con         = out_ready && (|r_main_v);
    w_main_v_kill = r_main_v & ~kill;
    // Head leaves either by consume (which overrides kill) or by kill
    // clearing every remaining lane.
    w_pop         = (r_state != ST_EMPTY) && (w_con || (w_main_v_kill == '0));
  end

  // Next-entry computation: remove the head first, then place an accepted
  // bundle in the next free slot of the post-removal state, keeping order.
  always_comb begin
    w_state_post  = r_state;
    w_main_v_post = w_con ? r_main_v : w_main_v_kill;
    w_main_d_post = r_main_d;
    w_skid_v_post = r_skid_v;
    w_skid_d_post = r_skid_d;
    if (r_state == ST_EMPTY) begin
      w_main_v_post = r_main_v;
    end else if (w_pop) begin
      if (r_state == ST_TWO) begin
        w_state_post  = ST_ONE;
        w_main_v_post = r_skid_v;
        w_main_d_post = r_skid_d;
        w_skid_v_post = '0;
      end else begin
        w_state_post  = ST_EMPTY;
        w_main_v_post = '0;
      end
    end

    w_state_nxt  = w_state_post;
    w_main_v_nxt = w_main_v_post;
    w_main_d_nxt = w_main_d_post;
    w_skid_v_nxt = w_skid_v_post;
    w_skid_d_nxt = w_skid_d_post;
    if (w_acc) begin
      case (w_state_post)
        ST_EMPTY: begin
          w_state_nxt  = ST_ONE;
          w_main_v_nxt = in_valid;
          w_main_d_nxt = in_data;
        end
        ST_ONE: begin
          w_state_nxt  = ST_TWO;
          w_skid_v_nxt = in_valid;
          w_skid_d_nxt = in_data;
        end
        default: ;
      endcase
    end

    // Flush empties the stage but leaves data registers untouched.
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_v_nxt = '0;
      w_skid_v_nxt = '0;
      w_main_d_nxt = r_main_d;
      w_skid_d_nxt = r_skid_d;
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_main_v <= '0;
      r_main_d <= '0;
      r_skid_v <= '0;
      r_skid_d <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_main_v <= w_main_v_nxt;
      r_main_d <= w_main_d_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_skid_d <= w_skid_d_nxt;
    end
  end

  // Outputs come straight from the main entry and the state register.
  always_comb begin
    out_valid = r_main_v;
    out_data  = r_main_d;
    occupancy = r_state;
  end

endmodule

// File: tb/tb_pl_stage_skid.sv
// Testbench for pl_stage_skid (LANES=2, DATA_W=8): directed scenarios plus
// randomized traffic checked against a queue-based model of the stage.
module tb_pl_stage_skid;

  localparam int unsigned LANES  = 2;
  localparam int unsigned DATA_W = 8;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [LANES-1:0]        kill;
  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_ready;
  logic [LANES-1:0]        out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_ready;
  logic [1:0]              occupancy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [LANES-1:0]        v;
    logic [LANES*DATA_W-1:0] d;
  } bundle_t;

  bundle_t q[$];

  pl_stage_skid #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stage as an ordered FIFO of at most two bundles.
  task automatic model_step();
    bundle_t b;
    bit      take;
    take = (q.size() < 2) && !rst && (in_valid != '0);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        if (out_ready) begin
          void'(q.pop_front());
        end else begin
          b = q[0];
          b.v = b.v & ~kill;
          if (b.v == '0) void'(q.pop_front());
          else q[0] = b;
        end
      end
      if (take) begin
        b.v = in_valid;
        b.d = in_data;
        q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; kill = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL reset_out_valid: got %b exp 00", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h exp 0000", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d exp 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] dl [3];
    dl[0] = 16'h0201; dl[1] = 16'h0403; dl[2] = 16'h0605;
    out_ready = 1'b1; in_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_data = dl[i];
      tick();
      n_cmp++; if (out_data !== dl[i]) begin n_err++; $display("FAIL stream_data[%0d]: got %h exp %h", i, out_data, dl[i]); end
      n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL stream_valid[%0d]: got %b exp 11", i, out_valid); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d exp 1", i, occupancy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, in_ready); end
    end
    in_valid = 2'b00;
    tick();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 2'b11; in_data = 16'hAA11;
    tick();
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ1: got %0d exp 1", occupancy); end
    in_data = 16'hBB22;
    tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ2: got %0d exp 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b exp 0", in_ready); end
    n_cmp++; if (out_data !== 16'hAA11) begin n_err++; $display("FAIL bp_head_full: got %h exp AA11", out_data); end
    // Offer while full: must not be taken.
    in_data = 16'hCC33; out_ready = 1'b1;
    tick();
    in_valid = 2'b00;
    n_cmp++; if (out_data !== 16'hBB22) begin n_err++; $display("FAIL bp_second: got %h exp BB22", out_data); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_after1: got %0d exp 1", occupancy); end
    tick();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL bp_occ_empty: got %0d exp 0", occupancy); end
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL bp_valid_empty: got %b exp 00", out_valid); end
  endtask

  task automatic fill_two(input logic [15:0] d0, input logic [15:0] d1);
    out_ready = 1'b0; kill = '0; in_valid = 2'b11;
    in_data = d0; tick();
    in_data = d1; tick();
    in_valid = 2'b00;
  endtask

  task automatic test_kill();
    fill_two(16'h1111, 16'h2222);
    kill = 2'b10;
    tick();
    n_cmp++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL kill_partial_valid: got %b exp 01", out_valid); end
    n_cmp++; if (out_data !== 16'h1111) begin n_err++; $display("FAIL kill_partial_data: got %h exp 1111", out_data); end
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL kill_partial_occ: got %0d exp 2", occupancy); end
    kill = 2'b01;
    tick();
    kill = '0;
    n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL kill_retire_valid: got %b exp 11", out_valid); end
    n_cmp++; if (out_data !== 16'h2222) begin n_err++; $display("FAIL kill_retire_data: got %h exp 2222", out_data); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL kill_retire_occ: got %0d exp 1", occupancy); end
    // Kill in ONE without consume also retires the entry.
    kill = 2'b11;
    tick();
    kill = '0;
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL kill_one_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_consume_beats_kill();
    // ONE: consume with a partial kill must empty the stage.
    out_ready = 1'b0; in_valid = 2'b11; in_data = 16'h3131;
    tick();
    in_valid = 2'b00; out_ready = 1'b1; kill = 2'b01;
    tick();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL cbk_one_occ: got %0d exp 0", occupancy); end
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL cbk_one_valid: got %b exp 00", out_valid); end
    // TWO: consume with kill promotes skid intact.
    fill_two(16'h4141, 16'h5252);
    out_ready = 1'b1; kill = 2'b10;
    tick();
    kill = '0; out_ready = 1'b0;
    n_cmp++; if (out_data !== 16'h5252) begin n_err++; $display("FAIL cbk_two_data: got %h exp 5252", out_data); end
    n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL cbk_two_valid: got %b exp 11", out_valid); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL cbk_two_occ: got %0d exp 1", occupancy); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    fill_two(16'h6161, 16'h7272);
    flush = 1'b1; in_valid = 2'b11; in_data = 16'hEEEE;
    tick();
    flush = 1'b0; in_valid = 2'b00;
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b exp 00", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d exp 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b exp 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL flush_ghost[%0d]: got %b exp 00", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_empty_offer_and_reset();
    out_ready = 1'b0; in_valid = 2'b11; in_data = 16'h3344;
    tick();
    in_valid = 2'b00; in_data = 16'h5566;
    tick();
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL empty_offer_occ: got %0d exp 1", occupancy); end
    n_cmp++; if (out_data !== 16'h3344) begin n_err++; $display("FAIL empty_offer_data: got %h exp 3344", out_data); end
    in_valid = 2'b10; in_data = 16'h7788;
    tick();
    in_valid = 2'b00;
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL pre_rst_occ: got %0d exp 2", occupancy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_during: got %b exp 0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL midrst_valid: got %b exp 00", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL midrst_data: got %h exp 0000", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL midrst_occ: got %0d exp 0", occupancy); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      kill      = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      in_valid  = 2'($urandom_range(0, 3));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
      n_cmp++; if (occupancy !== 2'(q.size())) begin n_err++; $display("FAIL rnd_occ[%0d]: got %0d exp %0d", i, occupancy, q.size()); end
      n_cmp++; if (in_ready !== ((q.size() < 2) && !rst)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, in_ready, (q.size() < 2) && !rst); end
      if (q.size() > 0) begin
        n_cmp++; if (out_valid !== q[0].v) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b exp %b", i, out_valid, q[0].v); end
        n_cmp++; if (out_data !== q[0].d) begin n_err++; $display("FAIL rnd_data[%0d]: got %h exp %h", i, out_data, q[0].d); end
      end else begin
        n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL rnd_valid_empty[%0d]: got %b exp 00", i, out_valid); end
      end
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_consume_beats_kill();
    test_flush();
    test_empty_offer_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
